// File: rtl/reduce_max_int_pkg.sv
// ============================================================================
// Module : reduce_pkg
// Brief  : Shared FSM state type and reduction-mode constants for reduce_max_int.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reduce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/reduce_max_int_cmp.sv
// ============================================================================
// Module : cmp_int_nbit
// Brief  : Combinational signed/unsigned magnitude compare, gt = a>b, lt = a<b.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_int_nbit #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
            assign lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
            assign lt = a < b;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/reduce_max_int.sv
// ============================================================================
// Module : reduce_max_int
// Brief  : Streaming max/min reduction over COUNT elements with handshakes.
//          Define REDUCE_MAX_INT_ARGMAX_EN to add the idx register and out_idx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reduce_max_int
    import reduce_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int COUNT  = 8,
    parameter int IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_min,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef REDUCE_MAX_INT_ARGMAX_EN
    output logic [IDX_W-1:0] out_idx,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam int              CNT_W    = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             mode;
    logic [CNT_W-1:0] cnt;
`ifdef REDUCE_MAX_INT_ARGMAX_EN
    logic [IDX_W-1:0] idx;
`endif

    logic cmp_gt;
    logic cmp_lt;
    logic accept;
    logic take;

    cmp_int_nbit #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a  (in_data),
        .b  (acc),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    assign accept = in_valid && in_ready;
    // Strict compare so ties keep the earliest element.
    assign take   = (mode == MODE_MIN) ? cmp_lt : cmp_gt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            mode      <= MODE_MAX;
            cnt       <= '0;
`ifdef REDUCE_MAX_INT_ARGMAX_EN
            idx       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc  <= in_data;
                        mode <= in_min;
`ifdef REDUCE_MAX_INT_ARGMAX_EN
                        idx  <= '0;
`endif
                        if (COUNT == 1) begin
                            state     <= DONE;
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (take) begin
                            acc <= in_data;
`ifdef REDUCE_MAX_INT_ARGMAX_EN
                            idx <= IDX_W'(cnt);
`endif
                        end
                        if (cnt == CNT_LAST) begin
                            state     <= DONE;
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = acc;
`ifdef REDUCE_MAX_INT_ARGMAX_EN
    assign out_idx  = idx;
`endif

endmodule

`default_nettype wire

// File: doc/reduce_max_int.md
# reduce_max_int

Streaming signed/unsigned integer max/min reduction unit, the parametrised successor to the combinational two-operand max block. It accepts a stream of COUNT WIDTH-bit elements over a valid/ready handshake and compares each element against a running extreme. After the last element it presents one result word, plus an optional index, on an output handshake. It sits between the PIM operand streamer and the result writeback path.

## Interface
- WIDTH, 16: element bit width, at least 2.
- COUNT, 8: elements per reduction, at least 1.
- IDX_W, $clog2(COUNT) (minimum 1): index width.
- SIGNED, 1: 1 means two's-complement compare, 0 means unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  element valid.
- in_ready  output  1  element accepted when in_valid && in_ready.
- in_data  input  WIDTH  element.
- in_min  input  1  0 selects max, 1 selects min; sampled only with element 0.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  WIDTH  extreme value.
- out_idx  output  IDX_W  position (0..COUNT-1) of the extreme; present only with ARGMAX_EN.

## Operation
- State machine has three states: IDLE, ACCUM and DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On accept: acc<=in_data, idx<=0, mode<=in_min, cnt<=1.
  - Next state is DONE if COUNT==1, otherwise ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: replace acc (and idx<=cnt) only if the element is strictly greater than acc (max mode) or strictly less than acc (min mode). Ties keep the earliest element.
  - cnt increments on each accept. The accept at cnt==COUNT-1 goes to DONE and clears cnt to 0.
  - Cycles with no accept hold all state.
- DONE:
  - in_ready=0, out_valid=1.
  - out_data=acc and out_idx=idx, both stable until the handshake.
  - On out_ready goes to IDLE. There is no bypass; the next element is accepted the following cycle at the earliest.
- Compare rules:
  - SIGNED=1: 0x8000 < 0x7FFF (WIDTH=16).
  - SIGNED=0: 0x8000 > 0x7FFF.
  - No arithmetic overflow is possible, because the compare is a magnitude/sign compare, not a subtract-and-test.
- in_min is ignored after element 0; a mid-stream change has no effect.
- cnt is $clog2(COUNT+1) bits wide and never exceeds COUNT-1 when stored.
- If rst_n is asserted mid-reduction, the partial result is discarded and no out_valid is issued.

## Timing
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE. out_valid=0, out_data=0, out_idx=0.
- Throughput is one element per cycle.
- Latency: out_valid rises on the first clock edge after the COUNT-th accept.
- A full reduction occupies at least COUNT+1 cycles (COUNT accepts plus one DONE cycle with out_ready=1).
- out_valid never drops without an out_ready handshake.
- All outputs are registered or decoded from state only; there is no combinational path from in_* to out_*.
- in_ready does not depend on in_valid.

## Configuration
- Macro REDUCE_MAX_INT_ARGMAX_EN.
- Defined: the idx register and the out_idx port exist; the index tracks the first occurrence of the extreme.
- Undefined: both the idx register and the out_idx port are removed. out_data behaviour is identical in both builds.

## Structure
- Package reduce_pkg holds:
  - the state enum typedef (IDLE/ACCUM/DONE);
  - the mode constants MODE_MAX=0 and MODE_MIN=1.
- Sub-module cmp_int_nbit (parameters WIDTH, SIGNED):
  - purely combinational;
  - outputs gt and lt for operands A and B;
  - instantiated once, comparing in_data against acc.
- The top level holds the FSM, counter and registers.

## Test plan
- WIDTH=16, SIGNED=1, max mode, stream {3,-7,12,12,0,-1,5,2} with out_ready=1 -> out_data=12, out_idx=2, out_valid exactly one cycle after the 8th accept.
- Min mode with the same stream -> out_data=-7 (0xFFF9), out_idx=1. Toggling in_min after element 0 -> result unchanged.
- SIGNED=0, max of {0x7FFF,0x8000,...0} -> 0x8000 at idx 1. SIGNED=1 on the same stream -> 0x7FFF at idx 0.
- Hold out_ready=0 for 5 cycles in DONE -> in_ready=0 and out_data/out_idx stable; one cycle after release -> in_ready=1, and a back-to-back second reduction is correct.
- Random in_valid gaps (50%) -> result matches the reference model; state holds on idle cycles.
- Assert rst_n after element 4 -> out_valid never rises. The next full stream {1..8} gives 8 at idx 7. COUNT=1 build: each element is echoed with idx 0.
